// File: rtl/cordic_prerotate.sv
// cordic_prerotate: folds rotation/vectoring operands into the CORDIC convergence range.
// Define CORDIC_PREROTATE_WRAP_EN for iterative 2pi reduction; otherwise |z| is clamped to PI.
module cordic_prerotate (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode_in,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        mode,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] z,
    output logic        flip,
    output logic [4:0]  iter_count
);
    localparam logic signed [16:0] PI      = 17'sd804;
    localparam logic signed [16:0] TWO_PI  = 17'sd1608;
    localparam logic signed [16:0] HALF_PI = 17'sd402;

    typedef enum logic [1:0] {IDLE, REDUCE, FOLD, HOLD} state_t;

    state_t             r_state;
    logic               r_in_ready, r_out_valid, r_mode, r_flip;
    logic [15:0]        r_x, r_y, r_zo, r_xi, r_yi;
    logic signed [16:0] r_z;
    logic [4:0]         r_iter;

    logic signed [16:0] w_zin_mag, w_zin, w_zf;
    logic [16:0]        w_zabs;
    logic [14:0]        w_zmag;
    logic [15:0]        w_zsm, w_xt, w_yt, w_xo, w_yo;
    logic               w_big, w_ypos, w_fold_p, w_fold_n, w_fold_v, w_flip;

    always_comb begin
        w_zin_mag = {2'b00, z_in[14:0]};
        w_zin     = z_in[15] ? -w_zin_mag : w_zin_mag;
        w_big     = r_mode && (r_z > PI || r_z < -PI);
        w_ypos    = !(r_yi[15] && |r_yi[14:0]);
        w_fold_p  = r_mode && r_z > HALF_PI;
        w_fold_n  = r_mode && r_z < -HALF_PI;
        w_fold_v  = !r_mode && r_xi[15] && |r_xi[14:0];
        w_flip    = w_fold_p || w_fold_n || w_fold_v;
        w_zf      = w_fold_p ? r_z - PI : w_fold_n ? r_z + PI :
                    w_fold_v ? (w_ypos ? r_z + PI : r_z - PI) : r_z;
        w_zabs    = w_zf[16] ? -w_zf : w_zf;
        w_zmag    = (w_zabs > 17'd32767) ? 15'h7fff : w_zabs[14:0];
        w_zsm     = (w_zmag == 15'd0) ? 16'h0000 : {w_zf[16], w_zmag};
        w_xt      = {r_xi[15] ^ w_flip, r_xi[14:0]};
        w_yt      = {r_yi[15] ^ w_flip, r_yi[14:0]};
        w_xo      = |r_xi[14:0] ? w_xt : 16'h0000;
        w_yo      = |r_yi[14:0] ? w_yt : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mode      <= 1'b0;
            r_flip      <= 1'b0;
            r_x         <= 16'h0000;
            r_y         <= 16'h0000;
            r_zo        <= 16'h0000;
            r_xi        <= 16'h0000;
            r_yi        <= 16'h0000;
            r_z         <= 17'sd0;
            r_iter      <= 5'd0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_mode     <= mode_in;
                    r_xi       <= x_in;
                    r_yi       <= y_in;
                    r_z        <= w_zin;
                    r_iter     <= 5'd0;
                    r_in_ready <= 1'b0;
                    r_state    <= REDUCE;
                end
`ifdef CORDIC_PREROTATE_WRAP_EN
                REDUCE: if (w_big) begin
                    r_z    <= r_z[16] ? r_z + TWO_PI : r_z - TWO_PI;
                    r_iter <= r_iter + 5'd1;
                end else begin
                    r_state <= FOLD;
                end
`else
                REDUCE: begin
                    r_z     <= w_big ? (r_z[16] ? -PI : PI) : r_z;
                    r_state <= FOLD;
                end
`endif
                FOLD: begin
                    r_x         <= w_xo;
                    r_y         <= w_yo;
                    r_zo        <= w_zsm;
                    r_flip      <= w_flip;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign mode       = r_mode;
    assign x          = r_x;
    assign y          = r_y;
    assign z          = r_zo;
    assign flip       = r_flip;
    assign iter_count = r_iter;
endmodule
